// File: rtl/tx_arbiter.sv
// Two-source packet arbiter in front of the MAC TX byte interface.
// Packet-locked round-robin grant with frame-length and stall-timeout enforcement.
module tx_arbiter #(
  parameter int MAX_LEN       = 1518,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s0_data,
  input  logic             s0_sop,
  input  logic             s0_eop,
  input  logic             s0_err,
  input  logic             s0_wren,
  output logic             s0_rdy,
  input  logic [7:0]       s1_data,
  input  logic             s1_sop,
  input  logic             s1_eop,
  input  logic             s1_err,
  input  logic             s1_wren,
  output logic             s1_rdy,
  output logic [7:0]       tx_data,
  output logic             tx_sop,
  output logic             tx_eop,
  output logic             tx_err,
  output logic             tx_wren,
  input  logic             tx_rdy,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] abort_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TERM, FLUSH} state_t;

  state_t             state, state_nxt;
  logic               owner, owner_nxt;
  logic               last_owner, last_owner_nxt;
  logic [LEN_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
  logic               abort_inc;
  logic [1:0]         drop_inc;
  logic [1:0]         rdy;
  logic [CNT_W:0]     drop_sum;

  logic [7:0] own_data;
  logic       own_sop, own_eop, own_err, own_wren;
  logic       req0, req1;

  assign own_data = owner ? s1_data : s0_data;
  assign own_sop  = owner ? s1_sop  : s0_sop;
  assign own_eop  = owner ? s1_eop  : s0_eop;
  assign own_err  = owner ? s1_err  : s0_err;
  assign own_wren = owner ? s1_wren : s0_wren;

  assign req0 = s0_wren & s0_sop;
  assign req1 = s1_wren & s1_sop;

  assign s0_rdy = rdy[0];
  assign s1_rdy = rdy[1];
  assign grant  = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign busy   = (state != IDLE);

  assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    byte_cnt_nxt   = byte_cnt;
    stall_cnt_nxt  = stall_cnt;
    abort_inc      = 1'b0;
    drop_inc       = 2'b00;
    rdy            = 2'b00;
    tx_data        = 8'h00;
    tx_sop         = 1'b0;
    tx_eop         = 1'b0;
    tx_err         = 1'b0;
    tx_wren        = 1'b0;

    case (state)
      IDLE: begin
        // Requesters are held with rdy=0 so their SOP beat is forwarded in GRANT.
        rdy[0]   = s0_wren & ~s0_sop;
        rdy[1]   = s1_wren & ~s1_sop;
        drop_inc = {1'b0, rdy[0]} + {1'b0, rdy[1]};
        if (req0 | req1) begin
          state_nxt     = GRANT;
          owner_nxt     = (req0 & req1) ? ~last_owner : req1;
          byte_cnt_nxt  = '0;
          stall_cnt_nxt = '0;
        end
      end

      GRANT: begin
        tx_data    = own_data;
        tx_sop     = own_sop;
        tx_eop     = own_eop;
        tx_err     = own_err;
        tx_wren    = own_wren;
        rdy[owner] = tx_rdy;
        // Last allowed byte without EOP: close the frame as errored.
        if (own_wren && !own_eop && byte_cnt == LEN_W'(MAX_LEN - 1)) begin
          tx_eop = 1'b1;
          tx_err = 1'b1;
        end
        if (own_wren) begin
          stall_cnt_nxt = '0;
          if (tx_rdy) begin
            byte_cnt_nxt = byte_cnt + 1'b1;
            if (own_eop) begin
              state_nxt      = IDLE;
              last_owner_nxt = owner;
            end else if (byte_cnt == LEN_W'(MAX_LEN - 1)) begin
              abort_inc = 1'b1;
              state_nxt = FLUSH;
            end
          end
        end else begin
          stall_cnt_nxt = stall_cnt + 1'b1;
          if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) state_nxt = TERM;
        end
      end

      TERM: begin
        tx_wren = 1'b1;
        tx_eop  = 1'b1;
        tx_err  = 1'b1;
        if (tx_rdy) begin
          abort_inc = 1'b1;
          state_nxt = FLUSH;
        end
      end

      FLUSH: begin
        rdy[owner] = 1'b1;
        if (own_wren && own_eop) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      byte_cnt   <= '0;
      stall_cnt  <= '0;
      abort_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      byte_cnt   <= byte_cnt_nxt;
      stall_cnt  <= stall_cnt_nxt;
      if (abort_inc && !(&abort_cnt)) abort_cnt <= abort_cnt + 1'b1;
      if (drop_inc != 2'b00) drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus randomized traffic
// scored against a packet-level reference model.
module tb_tx_arbiter;

  localparam int MAX_LEN       = 16;
  localparam int STALL_TIMEOUT = 8;
  localparam int CNT_W         = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  typedef struct {
    int    src;
    beat_t b;
    int    cyc;
  } log_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       s0_data, s1_data;
  logic             s0_sop, s0_eop, s0_err, s0_wren, s0_rdy;
  logic             s1_sop, s1_eop, s1_err, s1_wren, s1_rdy;
  logic [7:0]       tx_data;
  logic             tx_sop, tx_eop, tx_err, tx_wren, tx_rdy;
  logic [1:0]       grant;
  logic             busy;
  logic [CNT_W-1:0] abort_cnt, drop_cnt;

  tx_arbiter #(
    .MAX_LEN      (MAX_LEN),
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_data  (s0_data),
    .s0_sop   (s0_sop),
    .s0_eop   (s0_eop),
    .s0_err   (s0_err),
    .s0_wren  (s0_wren),
    .s0_rdy   (s0_rdy),
    .s1_data  (s1_data),
    .s1_sop   (s1_sop),
    .s1_eop   (s1_eop),
    .s1_err   (s1_err),
    .s1_wren  (s1_wren),
    .s1_rdy   (s1_rdy),
    .tx_data  (tx_data),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop),
    .tx_err   (tx_err),
    .tx_wren  (tx_wren),
    .tx_rdy   (tx_rdy),
    .grant    (grant),
    .busy     (busy),
    .abort_cnt(abort_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus queues per source and expected MAC-side beats per source.
  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  log_t  log_q[$];
  logic [1:0] pres = 2'b00;
  int idle_run[2];
  int idle_pct  = 0;
  int rdy_mode  = 0;
  int cyc       = 0;
  int exp_abort = 0;
  int exp_drop  = 0;
  int txw_cnt   = 0;
  int busy_fall = 0;

  logic             busy_s, txrdy_s;
  logic [1:0]       grant_s, srdy_s;
  logic [11:0]      txall_s;
  logic [CNT_W-1:0] abort_s, drop_s;

  task automatic drive(input int s, input logic v, input beat_t b);
    if (s == 0) begin
      s0_wren = v; s0_data = b.data; s0_sop = b.sop; s0_eop = b.eop; s0_err = b.err;
    end else begin
      s1_wren = v; s1_data = b.data; s1_sop = b.sop; s1_eop = b.eop; s1_err = b.err;
    end
  endtask

  // One clock: sample at negedge, score MAC beats, then update sources after posedge.
  task automatic step();
    logic [1:0] acc;
    beat_t      b;
    beat_t      nb;
    int         s;
    @(negedge clk);
    cyc++;
    if (busy_s === 1'b1 && busy === 1'b0) busy_fall = cyc;
    busy_s  = busy;
    grant_s = grant;
    txrdy_s = tx_rdy;
    srdy_s  = {s1_rdy, s0_rdy};
    txall_s = {tx_data, tx_sop, tx_eop, tx_err, tx_wren};
    abort_s = abort_cnt;
    drop_s  = drop_cnt;
    if (tx_wren === 1'b1) txw_cnt++;
    acc = {s1_wren & s1_rdy, s0_wren & s0_rdy};
    if (tx_wren === 1'b1 && tx_rdy === 1'b1) begin
      b = '{data: tx_data, sop: tx_sop, eop: tx_eop, err: tx_err};
      s = (grant == 2'b10) ? 1 : 0;
      check("beat_grant_onehot", 32'($onehot(grant)), 32'd1);
      check("beat_pending", 32'(exp_q[s].size() != 0), 32'd1);
      if (exp_q[s].size() != 0) check($sformatf("beat_s%0d", s), 32'(b), 32'(exp_q[s].pop_front()));
      log_q.push_back('{src: s, b: b, cyc: cyc});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        pres[i] = 1'b0;
      end
      if (!pres[i] && src_q[i].size() > 0) begin
        if (idle_run[i] >= 3 || $urandom_range(99) >= idle_pct) begin
          pres[i]     = 1'b1;
          idle_run[i] = 0;
        end else begin
          idle_run[i]++;
        end
      end
      nb = '0;
      if (pres[i]) nb = src_q[i][0];
      drive(i, pres[i], nb);
    end
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = ~tx_rdy;
      default: tx_rdy = ($urandom_range(99) < 60);
    endcase
  endtask

  // Reference model: what the MAC must receive for a packet of len bytes.
  task automatic send_pkt(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.sop  = (i == 0);
      b.eop  = (i == len - 1);
      b.err  = ($urandom_range(9) == 0);
      src_q[s].push_back(b);
      if (i < MAX_LEN) begin
        if (i == MAX_LEN - 1 && len > MAX_LEN) begin
          b.eop = 1'b1;
          b.err = 1'b1;
        end
        exp_q[s].push_back(b);
      end
    end
    if (len > MAX_LEN) exp_abort++;
  endtask

  task automatic send_stray(input int s);
    beat_t b;
    b.data = 8'($urandom);
    b.sop  = 1'b0;
    b.eop  = 1'b0;
    b.err  = 1'b0;
    src_q[s].push_back(b);
    exp_drop++;
  endtask

  task automatic run_done(input string tag, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((src_q[0].size() + src_q[1].size() != 0 || busy_s) && n < budget);
    check({tag, "_finished"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_end(input string tag);
    step();
    check({tag, "_exp0_empty"}, 32'(exp_q[0].size()), 32'd0);
    check({tag, "_exp1_empty"}, 32'(exp_q[1].size()), 32'd0);
    check({tag, "_abort_cnt"}, 32'(abort_s), 32'(exp_abort));
    check({tag, "_drop_cnt"}, 32'(drop_s), 32'(exp_drop));
    check({tag, "_idle"}, 32'(busy_s), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      pres[i]     = 1'b0;
      idle_run[i] = 0;
      drive(i, 1'b0, '0);
    end
    exp_abort = 0;
    exp_drop  = 0;
    step();
    rst = 1'b0;
    step();
    log_q.delete();
    txw_cnt = 0;
  endtask

  task automatic test_single();
    do_reset();
    send_pkt(0, MAX_LEN);
    run_done("single", 200);
    check("single_beats", 32'(log_q.size()), 32'(MAX_LEN));
    if (log_q.size() > 0) begin
      check("single_src", 32'(log_q[0].src), 32'd0);
      check("single_busy_fall", 32'(busy_fall - log_q[log_q.size()-1].cyc), 32'd1);
    end
    check_end("single");
  endtask

  task automatic test_contention();
    int sop_src[$];
    int sop_cyc[$];
    int eop_cyc[$];
    do_reset();
    send_pkt(0, 5);
    send_pkt(1, 4);
    run_done("rr_a", 200);
    send_pkt(0, 3);
    send_pkt(1, 3);
    run_done("rr_b", 200);
    foreach (log_q[i]) begin
      if (log_q[i].b.sop) begin
        sop_src.push_back(log_q[i].src);
        sop_cyc.push_back(log_q[i].cyc);
      end
      if (log_q[i].b.eop) eop_cyc.push_back(log_q[i].cyc);
    end
    check("rr_npkts", 32'(sop_src.size()), 32'd4);
    for (int i = 0; i < sop_src.size() && i < 4; i++)
      check($sformatf("rr_order%0d", i), 32'(sop_src[i]), 32'(i % 2));
    if (sop_cyc.size() >= 2 && eop_cyc.size() >= 1)
      check("rr_gap", 32'(sop_cyc[1] - eop_cyc[0]), 32'd2);
    check_end("rr");
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    rdy_mode = 1;
    send_pkt(1, 10);
    do begin
      step();
      n++;
      if (grant_s == 2'b10) begin
        check("bp_s1_rdy_mirror", 32'(srdy_s[1]), 32'(txrdy_s));
        check("bp_s0_rdy_low", 32'(srdy_s[0]), 32'd0);
      end
    end while ((src_q[1].size() != 0 || busy_s) && n < 200);
    check("bp_finished", 32'(n < 200), 32'd1);
    check("bp_beats", 32'(log_q.size()), 32'd10);
    check_end("bp");
    rdy_mode = 0;
  endtask

  task automatic test_overlength();
    do_reset();
    send_pkt(0, MAX_LEN + 4);
    run_done("ovl", 200);
    check("ovl_beats", 32'(log_q.size()), 32'(MAX_LEN));
    check("ovl_wren_cycles", 32'(txw_cnt), 32'(MAX_LEN));
    if (log_q.size() > 0)
      check("ovl_last_eop_err", 32'({log_q[log_q.size()-1].b.eop, log_q[log_q.size()-1].b.err}), 32'd3);
    check_end("ovl");
  endtask

  task automatic test_stall();
    beat_t b;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b.data = 8'(8'h10 + i);
      b.sop  = (i == 0);
      b.eop  = 1'b0;
      b.err  = 1'b0;
      src_q[1].push_back(b);
      exp_q[1].push_back(b);
    end
    b = '{data: 8'h00, sop: 1'b0, eop: 1'b1, err: 1'b1};
    exp_q[1].push_back(b);
    exp_abort++;
    repeat (20) step();
    check("stall_busy_in_flush", 32'(busy_s), 32'd1);
    b = '{data: 8'h55, sop: 1'b0, eop: 1'b1, err: 1'b0};
    src_q[1].push_back(b);
    run_done("stall", 200);
    check("stall_beats", 32'(log_q.size()), 32'd4);
    check("stall_wren_cycles", 32'(txw_cnt), 32'd4);
    if (log_q.size() >= 4)
      check("stall_gap", 32'(log_q[3].cyc - log_q[2].cyc), 32'(STALL_TIMEOUT + 1));
    check_end("stall");
  endtask

  task automatic test_stray_reset();
    do_reset();
    for (int i = 0; i < 3; i++) send_stray(0);
    run_done("stray", 100);
    check_end("stray");
    check("stray_no_wren", 32'(txw_cnt), 32'd0);
    send_pkt(0, 10);
    repeat (6) step();
    check("mid_pkt_busy", 32'(busy_s), 32'd1);
    do_reset();
    check("rst_mid_tx", 32'(txall_s), 32'd0);
    check("rst_mid_grant", 32'(grant_s), 32'd0);
    check("rst_mid_busy", 32'(busy_s), 32'd0);
    check("rst_mid_abort", 32'(abort_s), 32'd0);
    check("rst_mid_drop", 32'(drop_s), 32'd0);
  endtask

  task automatic test_random();
    do_reset();
    idle_pct = 25;
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) begin
      send_pkt(0, $urandom_range(1, MAX_LEN + 6));
      send_pkt(1, $urandom_range(1, MAX_LEN + 6));
    end
    run_done("rand", 20000);
    check_end("rand");
    idle_pct = 0;
    rdy_mode = 0;
  endtask

  initial begin
    rst      = 1'b1;
    tx_rdy   = 1'b0;
    busy_s   = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    do_reset();
    check("rst_tx", 32'(txall_s), 32'd0);
    check("rst_grant", 32'(grant_s), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_src_rdy", 32'(srdy_s), 32'd0);
    check("rst_abort", 32'(abort_s), 32'd0);
    check("rst_drop", 32'(drop_s), 32'd0);
    test_single();
    test_contention();
    test_backpressure();
    test_overlength();
    test_stall();
    test_stray_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
